alu_mc: RTL and testbench
=========================

ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 Parameter WIDTH, default 32, datapath width in bits; legal values are powers of two from 8 to 64.
REQ-002 Local parameter SHW = $clog2(WIDTH), the width of the shift amount.
REQ-003 clk  input  1  the single clock; all state changes on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request to begin an operation; sampled only while busy=0.
REQ-006 aluc  input  4  operation code; sampled with start.
REQ-007 ina  input  WIDTH  operand A; sampled with start.
REQ-008 inb  input  WIDTH  operand B, or shift amount in inb[SHW-1:0]; sampled with start.
REQ-009 cin  input  1  carry in; sampled with start.
REQ-010 busy  output  1  high while an accepted operation is in progress.
REQ-011 done  output  1  one-cycle pulse when out and the flags update.
REQ-012 out  output  WIDTH  registered result.
REQ-013 cout  output  1  registered carry out.
REQ-014 overflow  output  1  registered signed overflow.
REQ-015 zero  output  1  registered flag, high when out equals 0.

Function
REQ-016 The block SHALL use FSM states IDLE and EXEC: IDLE->EXEC on an accepted multi-cycle op; EXEC->IDLE on the final iteration edge.
REQ-017 An operation SHALL be accepted at edge E0 when start=1, busy=0 and rst=0; operands SHALL be latched at E0.
REQ-018 start while busy=1 SHALL be ignored, with no effect on operands or state.
REQ-019 Single-cycle ops SHALL be: 0000 A; 0001 B; 0010 ~A; 0011 ~B; 0100 A+B; 0101 A+B+cin; 0110 A|B; 0111 A&B; 1000 all-zero; 1001 one; 1010 all-ones. out and the flags SHALL load at E0, with done=1 in the following cycle and busy staying 0.
REQ-020 Multi-cycle ops SHALL be 1011 (logical shift left) and 1100 (logical shift right), by n = inb[SHW-1:0], one bit per cycle. busy=1 from E0 until the edge E0+n, when out loads, busy falls and done pulses. If n=0, the op SHALL behave as single-cycle with out=A.
REQ-021 For 0100/0101, cout SHALL be bit WIDTH of the (WIDTH+1)-bit sum, and overflow SHALL be (A[MSB]==B[MSB]) && (sum[MSB]!=A[MSB]).
REQ-022 For all other ops, cout and overflow SHALL be 0.
REQ-023 zero SHALL be computed from the value loaded into out.
REQ-024 Illegal codes (1110, 1111, and 1101 when multiply is excluded) SHALL complete as single-cycle ops with out=0, cout=0, overflow=0, zero=1.
REQ-025 out and the flags SHALL hold their values between done pulses; intermediate shift/multiply values SHALL be kept in internal registers, not in out.
REQ-026 done SHALL be high for exactly one cycle per accepted op.
REQ-027 A new op MAY be accepted in the same cycle that done is high.

Reset
REQ-028 When rst=1 at an edge: out=0, cout=0, overflow=0, zero=1, busy=0, done=0, state=IDLE, and the iteration counter cleared.
REQ-029 rst SHALL take priority over start and SHALL abort any op in progress without a done pulse.

Configuration
REQ-030 With macro ALU_MC_MUL_EN defined, op 1101 SHALL be an unsigned shift-add multiply, one partial product per cycle, busy for WIDTH cycles. done SHALL pulse after edge E0+WIDTH, with out = low WIDTH bits of A*B, cout = OR of the high WIDTH bits, and overflow=0.
REQ-031 Without ALU_MC_MUL_EN, no multiplier logic SHALL be synthesised, and 1101 SHALL be handled per REQ-024.

Verification
REQ-032 WIDTH=32, op 0100, A=32'hFFFFFFFF, B=1 -> next cycle done=1, out=0, cout=1, zero=1, overflow=0, busy never high.
REQ-033 op 0101, A=32'h7FFFFFFF, B=0, cin=1 -> out=32'h80000000, overflow=1, cout=0, zero=0.
REQ-034 op 1011, A=1, inb=5 -> busy high for 5 cycles, done at E0+5, out=32'h20. Same with inb=0 -> done the next cycle, out=1. op 1100, A=32'h80000000, inb=31 -> out=1.
REQ-035 With ALU_MC_MUL_EN, op 1101, A=1234, B=5678 -> done after 32 cycles, out=7006652, cout=0. Without the macro -> done the next cycle, out=0, zero=1.
REQ-036 During a 1101 op, pulse start with op 0001 -> ignored. Assert rst at cycle 10 -> next cycle busy=0, out=0, no done pulse. A following op 0000 with A=7 -> out=7.

Source files
------------

// File: rtl/alu_mc_if.sv
// Request/response bundle for alu_mc: operands and opcode in, result and flags out.
interface alu_mc_if #(parameter int WIDTH = 32);
  logic             start;
  logic [3:0]       aluc;
  logic [WIDTH-1:0] ina;
  logic [WIDTH-1:0] inb;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] out;
  logic             cout;
  logic             overflow;
  logic             zero;

  modport master (output start, aluc, ina, inb, cin,
                  input  busy, done, out, cout, overflow, zero);
  modport slave  (input  start, aluc, ina, inb, cin,
                  output busy, done, out, cout, overflow, zero);
endinterface

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/add ops plus bit-serial shifts.
// Define ALU_MC_MUL_EN to add a bit-serial unsigned shift-add multiplier on opcode 1101.
module alu_mc #(
  parameter int WIDTH = 32
) (
  input logic   clk,
  input logic   rst,
  alu_mc_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW:0] CNT_ONE = (SHW+1)'(1);
`ifdef ALU_MC_MUL_EN
  localparam logic [SHW:0] MUL_CNT = (SHW+1)'(WIDTH);
`endif

  typedef enum logic {IDLE, EXEC} state_t;
  typedef enum logic [1:0] {OP_SHL, OP_SHR, OP_MUL} mop_t;

  state_t           state;
  mop_t             mop;
  logic [SHW:0]     cnt;
  logic [WIDTH-1:0] sh;
  logic             busy_r, done_r, cout_r, ovf_r, zero_r;
  logic [WIDTH-1:0] out_r;

  logic [SHW-1:0]   n;
  logic             use_cin;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] sc_out;
  logic             sc_cout, sc_ovf, go_multi;
  logic [WIDTH-1:0] step_sh, fin_out;
  logic             fin_cout;

`ifdef ALU_MC_MUL_EN
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH:0]     psum;
  logic [2*WIDTH-1:0] prod_nxt;
`endif

  function automatic logic add_ovf(input logic signed [WIDTH-1:0] a,
                                   input logic signed [WIDTH-1:0] b,
                                   input logic signed [WIDTH-1:0] s);
    return (a[WIDTH-1] == b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
  endfunction

  assign n = bus.inb[SHW-1:0];

  // Decode of the op presented with start
  always_comb begin
    use_cin  = (bus.aluc == 4'b0101) & bus.cin;
    sum      = {1'b0, bus.ina} + {1'b0, bus.inb} + {{WIDTH{1'b0}}, use_cin};
    sc_out   = '0;
    sc_cout  = 1'b0;
    sc_ovf   = 1'b0;
    go_multi = 1'b0;
    case (bus.aluc)
      4'b0000: sc_out = bus.ina;
      4'b0001: sc_out = bus.inb;
      4'b0010: sc_out = ~bus.ina;
      4'b0011: sc_out = ~bus.inb;
      4'b0100, 4'b0101: begin
        sc_out  = sum[WIDTH-1:0];
        sc_cout = sum[WIDTH];
        sc_ovf  = add_ovf(bus.ina, bus.inb, sum[WIDTH-1:0]);
      end
      4'b0110: sc_out = bus.ina | bus.inb;
      4'b0111: sc_out = bus.ina & bus.inb;
      4'b1000: sc_out = '0;
      4'b1001: sc_out = WIDTH'(1);
      4'b1010: sc_out = '1;
      4'b1011, 4'b1100: begin
        sc_out   = bus.ina;
        go_multi = (n != '0);
      end
`ifdef ALU_MC_MUL_EN
      4'b1101: go_multi = 1'b1;
`endif
      default: sc_out = '0;
    endcase
  end

  // One iteration of the running shift or multiply
  always_comb begin
    step_sh  = (mop == OP_SHR) ? {1'b0, sh[WIDTH-1:1]} : {sh[WIDTH-2:0], 1'b0};
    fin_out  = step_sh;
    fin_cout = 1'b0;
`ifdef ALU_MC_MUL_EN
    psum     = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
    prod_nxt = {psum, prod[WIDTH-1:1]};
    if (mop == OP_MUL) begin
      fin_out  = prod_nxt[WIDTH-1:0];
      fin_cout = |prod_nxt[2*WIDTH-1:WIDTH];
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      out_r  <= '0;
      cout_r <= 1'b0;
      ovf_r  <= 1'b0;
      zero_r <= 1'b1;
      cnt    <= '0;
    end else begin
      done_r <= 1'b0;
      if (state == IDLE) begin
        if (bus.start) begin
          if (go_multi) begin
            state  <= EXEC;
            busy_r <= 1'b1;
            sh     <= bus.ina;
            cnt    <= {1'b0, n};
            mop    <= (bus.aluc == 4'b1100) ? OP_SHR :
                      (bus.aluc == 4'b1011) ? OP_SHL : OP_MUL;
`ifdef ALU_MC_MUL_EN
            prod   <= {{WIDTH{1'b0}}, bus.inb};
            mcand  <= bus.ina;
            if (bus.aluc == 4'b1101) cnt <= MUL_CNT;
`endif
          end else begin
            out_r  <= sc_out;
            cout_r <= sc_cout;
            ovf_r  <= sc_ovf;
            zero_r <= (sc_out == '0);
            done_r <= 1'b1;
          end
        end
      end else begin
        // Intermediate values live in sh/prod; out only loads on the last step
        sh  <= step_sh;
        cnt <= cnt - CNT_ONE;
`ifdef ALU_MC_MUL_EN
        prod <= prod_nxt;
`endif
        if (cnt == CNT_ONE) begin
          state  <= IDLE;
          busy_r <= 1'b0;
          done_r <= 1'b1;
          out_r  <= fin_out;
          cout_r <= fin_cout;
          ovf_r  <= 1'b0;
          zero_r <= (fin_out == '0);
        end
      end
    end
  end

  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.out      = out_r;
  assign bus.cout     = cout_r;
  assign bus.overflow = ovf_r;
  assign bus.zero     = zero_r;
endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc (WIDTH=32): directed ops, shift latencies, abort by reset.
module tb_alu_mc;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_mc_if #(.WIDTH(32)) bus();
  alu_mc #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [31:0] out;
    logic        cout;
    logic        ovf;
    logic        zero;
    int          cyc;
    string       nm;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  // Monitor: every done pulse is matched against the oldest expectation
  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b0 && bus.done === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL spurious_done: done=1 at cycle %0d, required done=0", cyc);
      end else begin
        e = sb.pop_front();
        chk({e.nm, "/out"},   bus.out, e.out);
        chk({e.nm, "/cout"},  {31'b0, bus.cout},     {31'b0, e.cout});
        chk({e.nm, "/ovf"},   {31'b0, bus.overflow}, {31'b0, e.ovf});
        chk({e.nm, "/zero"},  {31'b0, bus.zero},     {31'b0, e.zero});
        chk({e.nm, "/cycle"}, cyc, e.cyc);
        chk({e.nm, "/busy_at_done"}, {31'b0, bus.busy}, 32'd0);
      end
    end
  end

  task automatic issue(input string nm, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic c, input int lat, input logic mc,
                       input logic [31:0] eo, input logic ec, input logic ev, input logic push);
    int g = 0;
    @(negedge clk);
    while (bus.busy === 1'b1 && g < 200) begin
      g++;
      @(negedge clk);
    end
    if (g >= 200) chk({nm, "/idle_timeout"}, {31'b0, bus.busy}, 32'd0);
    bus.start = 1'b1;
    bus.aluc  = op;
    bus.ina   = a;
    bus.inb   = b;
    bus.cin   = c;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    if (push) sb.push_back('{eo, ec, ev, (eo == 32'd0), cyc + lat, nm});
    chk({nm, "/busy"}, {31'b0, bus.busy}, {31'b0, mc});
  endtask

  task automatic abort_test(input string nm, input logic [3:0] op, input logic [31:0] a,
                            input logic [31:0] b);
    issue(nm, op, a, b, 1'b0, 0, 1'b1, 32'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    bus.start = 1'b1;
    bus.aluc  = 4'b0001;
    bus.ina   = 32'd0;
    bus.inb   = 32'hDEAD;
    @(negedge clk);
    bus.start = 1'b0;
    chk({nm, "/busy_after_ignored_start"}, {31'b0, bus.busy}, 32'd1);
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk({nm, "/rst_busy"}, {31'b0, bus.busy}, 32'd0);
    chk({nm, "/rst_out"},  bus.out, 32'd0);
    chk({nm, "/rst_zero"}, {31'b0, bus.zero}, 32'd1);
    chk({nm, "/rst_done"}, {31'b0, bus.done}, 32'd0);
    @(negedge clk);
    chk({nm, "/no_done_after_abort"}, {31'b0, bus.done}, 32'd0);
  endtask

  initial begin
    exp_t e;
    int   g;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.aluc  = 4'b0000;
    bus.ina   = 32'd0;
    bus.inb   = 32'd0;
    bus.cin   = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset/out",  bus.out, 32'd0);
    chk("reset/zero", {31'b0, bus.zero}, 32'd1);
    chk("reset/busy", {31'b0, bus.busy}, 32'd0);
    chk("reset/done", {31'b0, bus.done}, 32'd0);
    chk("reset/cout", {31'b0, bus.cout}, 32'd0);
    chk("reset/ovf",  {31'b0, bus.overflow}, 32'd0);
    rst = 1'b0;

    //    name        op       A              B              cin lat mc  out            cout ovf push
    issue("add_wrap", 4'b0100, 32'hFFFFFFFF, 32'h00000001, 1'b0, 0, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1);
    issue("adc_ovf",  4'b0101, 32'h7FFFFFFF, 32'h00000000, 1'b1, 0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b1);
    issue("pass_a",   4'b0000, 32'h12345678, 32'h0000FFFF, 1'b0, 0, 1'b0, 32'h12345678, 1'b0, 1'b0, 1'b1);
    issue("pass_b",   4'b0001, 32'h12345678, 32'h0000ABCD, 1'b0, 0, 1'b0, 32'h0000ABCD, 1'b0, 1'b0, 1'b1);
    issue("not_a",    4'b0010, 32'h0F0F0F0F, 32'h00000000, 1'b0, 0, 1'b0, 32'hF0F0F0F0, 1'b0, 1'b0, 1'b1);
    issue("not_b",    4'b0011, 32'h00000000, 32'hFFFFFFFF, 1'b0, 0, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b1);
    issue("or",       4'b0110, 32'hF0F00000, 32'h0000000F, 1'b0, 0, 1'b0, 32'hF0F0000F, 1'b0, 1'b0, 1'b1);
    issue("and",      4'b0111, 32'hF0F0FFFF, 32'h0FF0F00F, 1'b0, 0, 1'b0, 32'h00F0F00F, 1'b0, 1'b0, 1'b1);
    issue("zeros",    4'b1000, 32'h11111111, 32'h22222222, 1'b0, 0, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b1);
    issue("one",      4'b1001, 32'h11111111, 32'h22222222, 1'b0, 0, 1'b0, 32'h00000001, 1'b0, 1'b0, 1'b1);
    issue("ones",     4'b1010, 32'h00000000, 32'h00000000, 1'b0, 0, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1);
    issue("add_negov",4'b0100, 32'h80000000, 32'h80000000, 1'b0, 0, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b1);
    issue("add_nocin",4'b0100, 32'h00000001, 32'h00000002, 1'b1, 0, 1'b0, 32'h00000003, 1'b0, 1'b0, 1'b1);
    issue("shl5",     4'b1011, 32'h00000001, 32'h00000005, 1'b0, 5, 1'b1, 32'h00000020, 1'b0, 1'b0, 1'b1);
    issue("shl0",     4'b1011, 32'h00000001, 32'h00000000, 1'b0, 0, 1'b0, 32'h00000001, 1'b0, 1'b0, 1'b1);
    issue("shr31",    4'b1100, 32'h80000000, 32'h0000001F, 1'b0, 31, 1'b1, 32'h00000001, 1'b0, 1'b0, 1'b1);
    issue("shl_hi",   4'b1011, 32'h00000003, 32'hFFFFFF25, 1'b0, 5, 1'b1, 32'h00000060, 1'b0, 1'b0, 1'b1);
    issue("shr1",     4'b1100, 32'h00000001, 32'h00000001, 1'b0, 1, 1'b1, 32'h00000000, 1'b0, 1'b0, 1'b1);
    issue("ill_e",    4'b1110, 32'h00000005, 32'h00000006, 1'b1, 0, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b1);
    issue("ill_f",    4'b1111, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 0, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b1);
`ifdef ALU_MC_MUL_EN
    issue("mul",      4'b1101, 32'd1234,     32'd5678,     1'b0, 32, 1'b1, 32'd7006652,  1'b0, 1'b0, 1'b1);
    issue("mul_hi",   4'b1101, 32'hFFFFFFFF, 32'h00000002, 1'b0, 32, 1'b1, 32'hFFFFFFFE, 1'b1, 1'b0, 1'b1);
    abort_test("abort_mul", 4'b1101, 32'd1234, 32'd5678);
`else
    issue("mul_off",  4'b1101, 32'd1234,     32'd5678,     1'b0, 0, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b1);
`endif
    abort_test("abort_shl", 4'b1011, 32'h00000001, 32'h00000014);
    issue("after_rst",4'b0000, 32'h00000007, 32'h00000000, 1'b0, 0, 1'b0, 32'h00000007, 1'b0, 1'b0, 1'b1);

    g = 0;
    while (sb.size() > 0 && g < 100) begin
      @(negedge clk);
      g++;
    end
    while (sb.size() > 0) begin
      e = sb.pop_front();
      n_cmp++;
      n_bad++;
      $display("FAIL %s/no_done: done never seen, required by cycle %0d", e.nm, e.cyc);
    end
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
